// File: rtl/conv_tile_line_buffer.sv
// conv_tile_line_buffer
// Buffers the last kx image rows of a raster pixel stream in kx circular
// row slots and presents zero-padded kx x (Pix+kx-1) tile windows to the
// convolution loop, one window per tile_ack handshake.
module conv_tile_line_buffer #(
  parameter int kx    = 3,
  parameter int Pix   = 3,
  parameter int RES   = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 4,
  localparam int NT     = IMG_W / Pix,
  localparam int WIN    = Pix + kx - 1,
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int TILE_W = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RES-1:0]                     in_pixel,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               tile_ack,
  output logic [kx-1:0][WIN-1:0][RES-1:0]    pixel_row,
  output logic                               pixel_ready,
  output logic [ROW_W-1:0]                   out_row,
  output logic [TILE_W-1:0]                  out_tile,
  output logic                               frame_done
);

  localparam int HALF   = kx / 2;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int WRR_W  = $clog2(IMG_H + 1);
  localparam int SLOT_W = (kx > 1) ? $clog2(kx) : 1;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t             state;
  logic [RES-1:0]     slot_mem [kx][IMG_W];
  logic [WRR_W-1:0]   wr_row;
  logic [COL_W-1:0]   wr_col;
  logic [SLOT_W-1:0]  wr_slot;
  logic               accept;
  logic               fill_last;
  int                 need_row;
  int                 rd_row;
  int                 rd_col;

  // Accept decode and detection of the last pixel of the deepest row the current output row needs
  always_comb begin
    accept    = (state == FILL) && in_valid && in_ready;
    need_row  = (int'(out_row) + HALF < IMG_H - 1) ? int'(out_row) + HALF : IMG_H - 1;
    wr_slot   = SLOT_W'(int'(wr_row) % kx);
    fill_last = accept && (int'(wr_row) == need_row) && (int'(wr_col) == IMG_W - 1);
  end

  // Row-slot storage; never cleared because out-of-image reads are padded by index
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_mem[wr_slot][wr_col] <= in_pixel;
    end
  end

  // Window read: slot (row mod kx), zero outside the image or while no tile is presented
  always_comb begin
    pixel_row = '0;
    rd_row    = 0;
    rd_col    = 0;
    for (int ky = 0; ky < kx; ky++) begin
      for (int j = 0; j < WIN; j++) begin
        rd_row = int'(out_row) + ky - HALF;
        rd_col = int'(out_tile) * Pix + j - HALF;
        if (pixel_ready && rd_row >= 0 && rd_row < IMG_H && rd_col >= 0 && rd_col < IMG_W) begin
          pixel_row[ky][j] = slot_mem[SLOT_W'(rd_row % kx)][COL_W'(rd_col)];
        end else begin
          pixel_row[ky][j] = '0;
        end
      end
    end
  end

  // Control FSM: FILL loads rows, PRESENT holds a tile until ack, GAP advances tile/row/frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      out_row     <= '0;
      out_tile    <= '0;
      wr_row      <= '0;
      wr_col      <= '0;
      in_ready    <= 1'b0;
      pixel_ready <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (int'(wr_col) == IMG_W - 1) begin
              wr_col <= '0;
              wr_row <= wr_row + 1'b1;
            end else begin
              wr_col <= wr_col + 1'b1;
            end
          end
          if (fill_last) begin
            state       <= PRESENT;
            in_ready    <= 1'b0;
            pixel_ready <= 1'b1;
          end else begin
            in_ready    <= 1'b1;
          end
        end
        PRESENT: begin
          in_ready <= 1'b0;
          if (tile_ack && pixel_ready) begin
            state       <= GAP;
            pixel_ready <= 1'b0;
            // Flag lands in the GAP cycle that closes the frame
            if (int'(out_tile) == NT - 1 && int'(out_row) == IMG_H - 1) begin
              frame_done <= 1'b1;
            end
          end
        end
        GAP: begin
          if (int'(out_tile) < NT - 1) begin
            out_tile    <= out_tile + 1'b1;
            state       <= PRESENT;
            pixel_ready <= 1'b1;
          end else if (int'(out_row) == IMG_H - 1) begin
            out_row  <= '0;
            out_tile <= '0;
            wr_row   <= '0;
            wr_col   <= '0;
            state    <= FILL;
            in_ready <= 1'b1;
          end else begin
            out_row  <= out_row + 1'b1;
            out_tile <= '0;
            // Bottom border rows need no new image row
            if (int'(out_row) + 1 + HALF <= IMG_H - 1) begin
              state    <= FILL;
              in_ready <= 1'b1;
            end else begin
              state       <= PRESENT;
              pixel_ready <= 1'b1;
            end
          end
        end
        default: begin
          state       <= FILL;
          in_ready    <= 1'b0;
          pixel_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_line_buffer.sv
// Self-checking bench for conv_tile_line_buffer: streams whole frames and
// compares every presented window against windows computed directly from
// an image array and the zero-padding rule.
module tb_conv_tile_line_buffer;

  localparam int KX    = 3;
  localparam int PIX   = 3;
  localparam int RES   = 8;
  localparam int IMG_W = 6;
  localparam int IMG_H = 4;
  localparam int HALF  = KX / 2;
  localparam int NT    = IMG_W / PIX;
  localparam int WIN   = PIX + KX - 1;

  typedef logic [KX-1:0][WIN-1:0][RES-1:0] win_t;
  typedef logic [127:0] val_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [RES-1:0] in_pixel;
  logic           in_valid;
  logic           in_ready;
  logic           tile_ack;
  win_t           pixel_row;
  logic           pixel_ready;
  logic [1:0]     out_row;
  logic [0:0]     out_tile;
  logic           frame_done;

  logic [RES-1:0] img [IMG_H][IMG_W];
  int             n_checks = 0;
  int             n_fail   = 0;

  conv_tile_line_buffer #(
    .kx(KX), .Pix(PIX), .RES(RES), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .tile_ack(tile_ack), .pixel_row(pixel_row),
    .pixel_ready(pixel_ready), .out_row(out_row), .out_tile(out_tile),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window straight from the definition: image[r+ky-HALF][t*PIX+j-HALF], 0 outside
  function automatic win_t exp_window(input int r, input int t);
    win_t w;
    int ir, ic;
    w = '0;
    for (int ky = 0; ky < KX; ky++) begin
      for (int j = 0; j < WIN; j++) begin
        ir = r + ky - HALF;
        ic = t * PIX + j - HALF;
        if (ir >= 0 && ir < IMG_H && ic >= 0 && ic < IMG_W) w[ky][j] = img[ir][ic];
        else w[ky][j] = '0;
      end
    end
    return w;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    tile_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("in_ready_held_after_rst", val_t'(in_ready), val_t'(0));
  endtask

  // Streams one frame; stop_pos >= 0 abandons the frame once that many pixels were accepted
  task automatic run_frame(input bit pattern, input bit gappy, input bit held, input int stop_pos);
    int  pos, need, budget;
    bit  acc, last;
    pos = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = pattern ? RES'(r * 16 + c + 1) : RES'($urandom_range(0, 255));
    tile_ack = held;
    for (int r = 0; r < IMG_H; r++) begin
      for (int t = 0; t < NT; t++) begin
        need = (((r + HALF) < (IMG_H - 1) ? (r + HALF) : (IMG_H - 1)) + 1) * IMG_W;
        if (pos < need) begin
          budget = 200;
          while (pos < need && pos != stop_pos && budget > 0) begin
            @(negedge clk);
            in_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_pixel = img[pos / IMG_W][pos % IMG_W];
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) pos++;
            budget--;
          end
          chk("fill_within_budget", val_t'(budget > 0), val_t'(1));
          if (pos == stop_pos) return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pixel_ready_on_time", val_t'(pixel_ready), val_t'(1));
        chk("in_ready_low_in_present", val_t'(in_ready), val_t'(0));
        chk("out_row", val_t'(out_row), val_t'(r));
        chk("out_tile", val_t'(out_tile), val_t'(t));
        chk("window", val_t'(pixel_row), val_t'(exp_window(r, t)));
        if (pattern && r == 0 && t == 0) begin
          chk("tile0_row1_j1", val_t'(pixel_row[1][1]), val_t'(8'd1));
          chk("tile0_row2_j4", val_t'(pixel_row[2][4]), val_t'(8'd20));
        end
        last = (r == IMG_H - 1) && (t == NT - 1);
        tile_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tile_ack = held;
        chk("gap_pixel_ready_low", val_t'(pixel_ready), val_t'(0));
        chk("frame_done_in_gap", val_t'(frame_done), val_t'(last));
        if (last) begin
          @(negedge clk);
          chk("in_ready_after_frame", val_t'(in_ready), val_t'(1));
          chk("frame_done_one_cycle", val_t'(frame_done), val_t'(0));
        end
      end
    end
    tile_ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    tile_ack = 1'b0;
    do_reset();
    chk("rst_pixel_ready", val_t'(pixel_ready), val_t'(0));
    chk("rst_frame_done", val_t'(frame_done), val_t'(0));
    chk("rst_out_row", val_t'(out_row), val_t'(0));
    chk("rst_out_tile", val_t'(out_tile), val_t'(0));

    // Pattern frame, in_valid constant, pulsed ack
    run_frame(1'b1, 1'b0, 1'b0, -1);
    // Random pixels with in_valid gaps
    run_frame(1'b0, 1'b1, 1'b0, -1);
    // Random pixels, tile_ack held high throughout
    run_frame(1'b0, 1'b1, 1'b1, -1);
    // Abandon a frame part-way through filling row 2
    run_frame(1'b1, 1'b0, 1'b0, 2 * IMG_W + 3);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", val_t'(in_ready), val_t'(0));
    chk("async_rst_pixel_ready", val_t'(pixel_ready), val_t'(0));
    chk("async_rst_frame_done", val_t'(frame_done), val_t'(0));
    chk("async_rst_out_row", val_t'(out_row), val_t'(0));
    chk("async_rst_out_tile", val_t'(out_tile), val_t'(0));
    chk("async_rst_pixel_row", val_t'(pixel_row), val_t'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Restream from the first pixel after the mid-frame reset
    run_frame(1'b1, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_tile_line_buffer.md
Name: conv_tile_line_buffer

Overview:
- Upstream feeder for the Pix-wide convolution loop.
- Accepts a raster-order pixel stream (one pixel per cycle, valid/ready) and stores the last kx image rows in kx circular row slots.
- Presents one zero-padded tile window per handshake: kx rows × (Pix+kx-1) pixels, on pixel_row with pixel_ready.
- The consumer returns tile_ack when it has finished the tile.

Parameters:
- kx, 3, kernel height/width (odd).
- Pix, 3, output pixels per tile.
- RES, 8, pixel bit width.
- IMG_W, 6, image width in pixels; must be a multiple of Pix.
- IMG_H, 4, image height in rows; must be ≥ kx/2+1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_pixel  input  RES  streamed pixel, raster order.
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block accepts in_pixel this cycle.
- tile_ack  input  1  consumer done with the presented tile.
- pixel_row  output  RES × [kx][Pix+kx-1]  tile window; entry [ky][j] = image[r+ky-kx/2][t*Pix+j-kx/2], 0 when outside the image.
- pixel_ready  output  1  pixel_row valid and stable.
- out_row  output  clog2(IMG_H)  current output row r.
- out_tile  output  clog2(IMG_W/Pix)  current tile index t.
- frame_done  output  1  one-cycle pulse after the last tile of a frame is acked.

Behaviour:
- Reset (async, rst=1):
  - State goes to FILL.
  - r=0, t=0, wr_row=0, wr_col=0.
  - in_ready=0, pixel_ready=0, frame_done=0.
  - Row-slot storage is not cleared; padding is by index, so stale data is never output.
  - in_ready rises the first cycle after rst deasserts.
  - rst mid-frame abandons the frame; the next pixel accepted is image[0][0].
- States: FILL, PRESENT, GAP.
- FILL:
  - in_ready=1; a pixel is accepted when in_valid && in_ready.
  - Write target is slot[wr_row mod kx][wr_col]. wr_col wraps at IMG_W-1 to 0 and increments wr_row.
  - Completion condition: the accepted pixel is the last column of row need = min(r+kx/2, IMG_H-1). On that edge: go to PRESENT; in_ready=0 and pixel_ready=1 from the next cycle.
- PRESENT:
  - pixel_ready=1.
  - pixel_row is driven combinationally from the slots plus the padding rule and held stable.
  - Row r+ky is read from slot (r+ky) mod kx.
  - in_valid is ignored; no pixel is accepted.
  - tile_ack=1 → go to GAP, pixel_ready=0 next cycle.
  - tile_ack with pixel_ready=0 is ignored.
- GAP (exactly one cycle, pixel_ready=0; gives the consumer a clean rising edge):
  - If t < IMG_W/Pix-1: t++, go to PRESENT.
  - Else if r = IMG_H-1: frame_done=1 this cycle; r=0, t=0, wr_row=0; go to FILL.
  - Else: r++, t=0. If r_new+kx/2 ≤ IMG_H-1, go to FILL (one more row needed). Otherwise go to PRESENT (bottom border, no new row).
- Overwrite safety:
  - The row loaded for r+1 replaces row r-kx/2 in the same slot. This slot is no longer needed.
  - Loading never overlaps PRESENT.
- Frame start needs rows 0..kx/2, so the first FILL accepts (kx/2+1)·IMG_W pixels.
- Padding:
  - Image column < 0 or ≥ IMG_W → 0.
  - Image row < 0 or ≥ IMG_H → 0.
- Latency (in_valid held high): last needed pixel accepted on edge N → pixel_ready high in cycle N+1.
- Ack-to-next-tile turnaround is 2 cycles when no FILL is needed.
- Throughput is not overlapped: in_ready stays low during PRESENT and GAP.

Test Plan:
1. kx=3, Pix=3, IMG_W=6, IMG_H=4, pixel = row·16+col+1. Stream 12 pixels with in_valid constant → pixel_ready high 1 cycle after the 12th acceptance.
   - Tile 0: row[0]={0,0,0,0,0}, row[1]={0,1,2,3,4}, row[2]={0,17,18,19,20}; out_row=0, out_tile=0.
2. Same setup, tile_ack on tile 0 → pixel_ready low 1 cycle, then high with out_tile=1.
   - row[1]={3,4,5,6,0}, row[2]={19,20,21,22,0}.
3. After tile 1 of row 0 is acked → FILL; in_ready=1; exactly 6 pixels are accepted, then row r=1 is presented.
   - row[0]={0,1,2,3,4}, row[2]={0,33,34,35,36}.
   - in_valid gaps only delay the window; contents are unchanged.
4. Row r=3 (bottom) → reached without a FILL; row[2] all zeros.
   - The last ack produces a frame_done pulse 1 cycle wide; in_ready=1 next.
5. tile_ack held high continuously → each tile is shown for exactly 1 cycle with 1-cycle gaps.
   - tile_ack during GAP is ignored; no tile is skipped.
6. rst asserted mid-FILL of row 2 (asynchronously, between edges) → outputs 0 immediately.
   - After release, restreaming from pixel 1 reproduces scenario 1's window exactly.
